// File: rtl/seven_seg_scan_4.sv
//------------------------------------------------------------------------------
// Module      : seven_seg_scan_4
// Description : Four-digit multiplexed 7-segment driver with frame-aligned
//               display updates. Define SEVEN_SEG_SCAN_BLANK_EN to enable
//               leading-zero blanking.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seven_seg_scan_4 #(
    parameter int CLK_DIV = 50000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Load,
    input  logic [3:0] Digit3,
    input  logic [3:0] Digit2,
    input  logic [3:0] Digit1,
    input  logic [3:0] Digit0,
    input  logic [3:0] DotMask,
    output logic [3:0] Anodes,
    output logic [6:0] Segments,
    output logic       Dot,
    output logic       FrameDone
);

    localparam int            PS_WIDTH = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(CLK_DIV - 1);

    // Packed display word layout: {dot_mask, digit3, digit2, digit1, digit0}
    logic [PS_WIDTH-1:0] prescaler;
    logic [1:0]          scan_idx;
    logic [19:0]         disp_reg;
    logic [19:0]         pend_reg;
    logic                pend_flag;
    logic                tick;
    logic                wrap_tick;
    logic [19:0]         load_word;
    logic [3:0]          blank;
    logic [3:0]          cur_digit;
    logic [6:0]          cur_seg;
    logic [3:0]          dot_vec;

    assign tick      = (prescaler == PS_LAST);
    assign wrap_tick = tick && (scan_idx == 2'd3);
    assign load_word = {DotMask, Digit3, Digit2, Digit1, Digit0};
    assign dot_vec   = disp_reg[19:16];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            prescaler <= '0;
            scan_idx  <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            scan_idx  <= scan_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // The display word only changes on the frame wrap so a frame never mixes
    // old and new digits; a Load on that same tick bypasses the pending stage.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            disp_reg  <= '0;
            pend_reg  <= '0;
            pend_flag <= 1'b0;
        end else if (wrap_tick) begin
            if (Load) begin
                disp_reg <= load_word;
            end else if (pend_flag) begin
                disp_reg <= pend_reg;
            end
            pend_flag <= 1'b0;
        end else if (Load) begin
            pend_reg  <= load_word;
            pend_flag <= 1'b1;
        end
    end

    always_comb begin
        blank = 4'b0000;
`ifdef SEVEN_SEG_SCAN_BLANK_EN
        blank[3] = (disp_reg[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_reg[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_reg[7:4] == 4'd0);
`endif
    end

    always_comb begin
        cur_digit = disp_reg[3:0];
        case (scan_idx)
            2'd0: cur_digit = disp_reg[3:0];
            2'd1: cur_digit = disp_reg[7:4];
            2'd2: cur_digit = disp_reg[11:8];
            2'd3: cur_digit = disp_reg[15:12];
            default: cur_digit = disp_reg[3:0];
        endcase
        cur_seg = blank[scan_idx] ? 7'h7F : seg_decode(cur_digit);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Anodes    <= 4'hF;
            Segments  <= 7'h7F;
            Dot       <= 1'b1;
            FrameDone <= 1'b0;
        end else begin
            Anodes    <= ~(4'b0001 << scan_idx);
            Segments  <= cur_seg;
            Dot       <= ~dot_vec[scan_idx];
            FrameDone <= wrap_tick;
        end
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan_4.md
SEVEN_SEG_SCAN_4 -- requirements
Module: seven_seg_scan_4

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning Clock cycles per digit slot (legal >= 1).
REQ-002 SHALL have port Clock, input, 1, meaning sole clock, all flops rising-edge.
REQ-003 SHALL have port Reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port Load, input, 1, meaning one-cycle strobe capturing Digit3..Digit0 and DotMask.
REQ-005 SHALL have ports Digit3, Digit2, Digit1, Digit0, each input, 4, meaning BCD digits, Digit3 most significant.
REQ-006 SHALL have port DotMask, input, 4, meaning bit n lights decimal point of digit n.
REQ-007 SHALL have port Anodes, output, 4, meaning active-low one-hot digit select, bit n = digit n.
REQ-008 SHALL have port Segments, output, 7, meaning active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port Dot, output, 1, meaning active-low decimal point.
REQ-010 SHALL have port FrameDone, output, 1, meaning one-cycle pulse at frame boundary.

Function
REQ-011 SHALL count prescaler 0..CLK_DIV-1, wrapping to 0; tick = prescaler at CLK_DIV-1 (CLK_DIV=1: tick every cycle).
REQ-012 SHALL advance scan index 0->1->2->3->0 on each tick only.
REQ-013 SHALL, on Load high, copy all inputs into a pending register and set pending flag; repeated Load before apply: last wins.
REQ-014 SHALL copy pending into display register and clear flag on the tick wrapping index 3->0; no mid-frame update.
REQ-015 SHALL, when Load coincides with the wrap tick, apply that cycle's inputs directly to display register, leaving flag clear.
REQ-016 SHALL register all outputs: Anodes = ~(1<<index), Segments/Dot from display digit at index, valid one cycle after index changes.
REQ-017 SHALL decode (hex, active-low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10; 10..15 = 3F (dash).
REQ-018 SHALL drive Dot = ~DotMask[index] from display register.
REQ-019 SHALL pulse FrameDone high exactly one cycle, registered, the cycle after the wrap tick.

Reset
REQ-020 SHALL, while Reset_n low: prescaler 0, index 0, display and pending registers 0, flag 0, Anodes 4'hF, Segments 7'h7F, Dot 1, FrameDone 0.
REQ-021 SHALL, on reset assertion mid-frame or with pending data, discard pending data; first edge after release shows digit 0.

Configuration
REQ-022 SHALL compile leading-zero blanking only when SEVEN_SEG_SCAN_BLANK_EN is defined.
REQ-023 SHALL, with macro: blank Digit3 if 0; Digit2 if Digit3 blanked and 0; Digit1 likewise; Digit0 never; blanked digit Segments 7'h7F, Dot unaffected.
REQ-024 SHALL, without macro, display all four digits, zeros as 7'h40.

Verification (CLK_DIV=4)
REQ-025 SHALL check reset: Reset_n low -> Anodes 4'hF, Segments 7'h7F, Dot 1; release -> next edge Anodes 4'b1110, Segments 7'h40.
REQ-026 SHALL check scan: free run 16 cycles -> Anodes 1110,1101,1011,0111 each held 4 cycles, FrameDone one pulse per 16.
REQ-027 SHALL check deferred load: Load 1,2,3,4 mid-frame -> display unchanged until wrap, then digit3 slot shows 7'h79 (1).
REQ-028 SHALL check last-wins/coincidence: two Loads (5678 then 9012) in a frame -> 9012 shown; Load on wrap tick -> applied immediately.
REQ-029 SHALL check blanking: digits 0,0,0,7 with macro -> slots 3..1 Segments 7'h7F, slot 0 7'h78; without macro -> 7'h40,7'h40,7'h40,7'h78.
REQ-030 SHALL check decode/dot: digit 4'hC, DotMask 4'b0100 -> Segments 7'h3F; slot 2 Dot 0, others 1.
